// File: rtl/rf_valid_tracker_if.sv
// Enqueue, commit, issue-queue and lookup bundle for rf_valid_tracker.
// slave = tracker side, master = rename/queue side driving qualifiers.
interface rf_valid_tracker_if #(
  parameter int AREGS      = 128,
  parameter int IQ_ENTRIES = 8,
  parameter int QSLOTS     = 2,
  parameter int RBIT       = 5
);
  localparam int RW = $clog2(AREGS);

  logic                                ce;
  logic                                branchmiss;
  logic [QSLOTS-1:0]                   queuedOn;
  logic [QSLOTS-1:0]                   slot_rfw;
  logic [QSLOTS-1:0]                   brk;
  logic [QSLOTS-1:0]                   slot_jmp;
  logic [QSLOTS-1:0]                   take_branch;
  logic [QSLOTS-1:0][RW-1:0]           Rd;
  logic [QSLOTS-1:0][RW-1:0]           Rs1;
  logic [QSLOTS-1:0][RW-1:0]           Rs2;
  logic [2*QSLOTS-1:0][RBIT-1:0]       rob_tails;
  logic [AREGS-1:0][RBIT-1:0]          rf_source;
  logic [1:0]                          cmt_v;
  logic [1:0]                          cmt_rfw;
  logic [1:0][RW-1:0]                  cmt_tgt;
  logic [1:0][RBIT-1:0]                cmt_rid;
  logic [IQ_ENTRIES-1:0]               iq_v;
  logic [IQ_ENTRIES-1:0]               iq_done;
  logic [IQ_ENTRIES-1:0]               iq_rfw;
  logic [IQ_ENTRIES-1:0][AREGS-1:0]    iq_latestID;
  logic [IQ_ENTRIES-1:0][RW-1:0]       iq_tgt;
  logic [AREGS-1:0]                    rf_v;
  logic [QSLOTS-1:0]                   rs1_v;
  logic [QSLOTS-1:0]                   rs2_v;
  logic [QSLOTS-1:0][RBIT-1:0]         rs1_src;
  logic [QSLOTS-1:0][RBIT-1:0]         rs2_src;
  logic                                recovering;

  modport slave (
    input  ce, branchmiss, queuedOn, slot_rfw, brk, slot_jmp,
           take_branch, Rd, Rs1, Rs2, rob_tails, rf_source,
           cmt_v, cmt_rfw, cmt_tgt, cmt_rid,
           iq_v, iq_done, iq_rfw, iq_latestID, iq_tgt,
    output rf_v, rs1_v, rs2_v, rs1_src, rs2_src, recovering
  );

  modport master (
    output ce, branchmiss, queuedOn, slot_rfw, brk, slot_jmp,
           take_branch, Rd, Rs1, Rs2, rob_tails, rf_source,
           cmt_v, cmt_rfw, cmt_tgt, cmt_rid,
           iq_v, iq_done, iq_rfw, iq_latestID, iq_tgt,
    input  rf_v, rs1_v, rs2_v, rs1_src, rs2_src, recovering
  );
endinterface

// File: rtl/rf_valid_tracker.sv
// Per-register committed-valid bits, operand lookup and branch-miss rebuild.
// Ports: clk, rst (sync, active-high), bus (rf_valid_tracker_if.slave).
module rf_valid_tracker #(
  parameter int AREGS      = 128,
  parameter int IQ_ENTRIES = 8,
  parameter int QSLOTS     = 2,
  parameter int RBIT       = 5,
  parameter int ZREG       = 0
) (
  input logic                 clk,
  input logic                 rst,
  rf_valid_tracker_if.slave   bus
);
  localparam int RW = $clog2(AREGS);
  localparam logic [RW-1:0] ZR = RW'(ZREG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_D1,
    S_D2,
    S_REBUILD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_bm_d;
  logic [AREGS-1:0]   r_rf_v;
  logic [AREGS-1:0]   w_rf_nxt;
  logic [1:0]         w_wr;
  logic [RBIT-1:0]    w_tag0;
  logic [RBIT-1:0]    w_tag1;
  logic               w_bm_rise;

  logic [QSLOTS-1:0]           w_rs1_v;
  logic [QSLOTS-1:0]           w_rs2_v;
  logic [QSLOTS-1:0][RBIT-1:0] w_rs1_src;
  logic [QSLOTS-1:0][RBIT-1:0] w_rs2_src;

  // Slot acceptance mirrors the source table so both agree on writers.
  assign w_wr[0] = bus.queuedOn[0] & bus.slot_rfw[0];
  assign w_wr[1] = bus.queuedOn[1] & bus.slot_rfw[1]
                 & ~bus.brk[0] & ~bus.slot_jmp[0]
                 & ~bus.take_branch[0];
  assign w_tag0  = bus.rob_tails[0];
  // A lone slot1 takes the first allocated ROB id.
  assign w_tag1  = bus.queuedOn[0] ? bus.rob_tails[1]
                                   : bus.rob_tails[0];

  assign w_bm_rise = bus.branchmiss & ~r_bm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bm_d  <= 1'b0;
      r_rf_v  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_bm_d  <= bus.branchmiss;
      r_rf_v  <= w_rf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_bm_rise) w_state_nxt = S_D1;
      S_D1:      w_state_nxt = S_D2;
      S_D2:      w_state_nxt = S_REBUILD;
      S_REBUILD: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rf_nxt = r_rf_v;
    if (r_state == S_REBUILD) begin
      // Only still-pending newest writers leave their target invalid.
      w_rf_nxt = '1;
      for (int n = 0; n < IQ_ENTRIES; n++) begin
        if (bus.iq_v[n] & bus.iq_rfw[n] & ~bus.iq_done[n]
            & (|bus.iq_latestID[n]))
          w_rf_nxt[bus.iq_tgt[n]] = 1'b0;
      end
    end else if (bus.ce) begin
      for (int c = 0; c < 2; c++) begin
        if (bus.cmt_v[c] & bus.cmt_rfw[c]
            & (bus.rf_source[bus.cmt_tgt[c]] == bus.cmt_rid[c]))
          w_rf_nxt[bus.cmt_tgt[c]] = 1'b1;
      end
      // Enqueue after commit so a same-cycle clear wins.
      if (w_wr[0]) w_rf_nxt[bus.Rd[0]] = 1'b0;
      if (w_wr[1]) w_rf_nxt[bus.Rd[1]] = 1'b0;
    end
    w_rf_nxt[ZREG] = 1'b1;
  end

  always_comb begin
    for (int s = 0; s < QSLOTS; s++) begin
      w_rs1_v[s]   = r_rf_v[bus.Rs1[s]];
      w_rs1_src[s] = bus.rf_source[bus.Rs1[s]];
      w_rs2_v[s]   = r_rf_v[bus.Rs2[s]];
      w_rs2_src[s] = bus.rf_source[bus.Rs2[s]];
      // Later slots see slot0's write before the source table does.
      if (s != 0 && w_wr[0] && bus.Rd[0] == bus.Rs1[s]) begin
        w_rs1_v[s]   = 1'b0;
        w_rs1_src[s] = w_tag0;
      end
      if (s != 0 && w_wr[0] && bus.Rd[0] == bus.Rs2[s]) begin
        w_rs2_v[s]   = 1'b0;
        w_rs2_src[s] = w_tag0;
      end
      if (bus.Rs1[s] == ZR) w_rs1_v[s] = 1'b1;
      if (bus.Rs2[s] == ZR) w_rs2_v[s] = 1'b1;
    end
  end

  assign bus.rf_v       = r_rf_v;
  assign bus.rs1_v      = w_rs1_v;
  assign bus.rs2_v      = w_rs2_v;
  assign bus.rs1_src    = w_rs1_src;
  assign bus.rs2_src    = w_rs2_src;
  assign bus.recovering = (r_state != S_IDLE);

  // Slot1's tag is only needed for the source table, kept for symmetry.
  logic w_unused;
  assign w_unused = ^w_tag1;
endmodule
